// File: rtl/sprite_line_scheduler.sv
// Sprite line scheduler.
// During horizontal blanking, walks every sprite, tests it for a vertical hit on
// the line being built, fetches the matching bitmap row over a request/grant
// port and hands it to the compositor's per-sprite line slots.
module sprite_line_scheduler #(
   parameter int  NUM_SPR = 4,
   parameter int  SPR_W   = 12,
   parameter int  SPR_H   = 12,
   localparam int IDX_W   = $clog2(NUM_SPR),
   localparam int ROW_W   = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     line_start,
   input  logic [7:0]               next_line,
   input  logic [NUM_SPR-1:0]       spr_en,
   input  logic [NUM_SPR*8-1:0]     spr_x,
   input  logic [NUM_SPR*8-1:0]     spr_y,
   output logic                     mem_req,
   output logic [IDX_W+ROW_W-1:0]   mem_addr,
   input  logic                     mem_gnt,
   input  logic [SPR_W-1:0]         mem_rdata,
   output logic                     slot_wr,
   output logic [IDX_W-1:0]         slot_idx,
   output logic [SPR_W-1:0]         slot_bits,
   output logic [7:0]               slot_x,
   output logic [NUM_SPR-1:0]       slot_valid,
   output logic                     busy,
   output logic                     done,
   output logic                     overrun,
   input  logic                     overrun_clr
);

   localparam logic [7:0]       SPR_H_B  = 8'(SPR_H);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SPR - 1);

   typedef enum logic [2:0] {
      IDLE,
      CHECK,
      REQ,
      WAIT,
      DONE
   } state_t;

   state_t           state_reg;
   logic [IDX_W-1:0] idx_reg;
   logic [7:0]       line_q_reg;
   logic [ROW_W-1:0] row_reg;

   logic [7:0] spr_x_arr [NUM_SPR];
   logic [7:0] spr_y_arr [NUM_SPR];

   // Unpack the flat coordinate buses into per-sprite views
   generate
      for (genvar gi = 0; gi < NUM_SPR; gi++) begin : g_spr_unpack
         assign spr_x_arr[gi] = spr_x[8*gi +: 8];
         assign spr_y_arr[gi] = spr_y[8*gi +: 8];
      end
   endgenerate

   logic [7:0] cur_y;
   logic [7:0] diff;
   logic       hit;
   logic       last_spr;

   // Vertical hit test for the sprite under the index; the >= term stops a
   // sprite near the bottom of the range from wrapping onto the top lines
   assign cur_y    = spr_y_arr[idx_reg];
   assign diff     = line_q_reg - cur_y;
   assign hit      = spr_en[idx_reg] && (line_q_reg >= cur_y) && (diff < SPR_H_B);
   assign last_spr = (idx_reg == LAST_IDX);

   // Address is built from registered fields only, so it stays stable during a stalled request
   assign mem_addr = {idx_reg, row_reg};

   // Scheduler FSM with all outputs registered
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg  <= IDLE;
         idx_reg    <= '0;
         line_q_reg <= '0;
         row_reg    <= '0;
         mem_req    <= 1'b0;
         slot_wr    <= 1'b0;
         slot_idx   <= '0;
         slot_bits  <= '0;
         slot_x     <= '0;
         slot_valid <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         slot_wr <= 1'b0;
         done    <= 1'b0;

         // A new line request while a schedule is running is dropped but remembered; set beats clear
         if (line_start && (state_reg != IDLE)) begin
            overrun <= 1'b1;
         end else if (overrun_clr) begin
            overrun <= 1'b0;
         end

         case (state_reg)
            IDLE: begin
               if (line_start) begin
                  line_q_reg <= next_line;
                  idx_reg    <= '0;
                  slot_valid <= '0;
                  busy       <= 1'b1;
                  state_reg  <= CHECK;
               end
            end

            CHECK: begin
               if (hit) begin
                  row_reg   <= diff[ROW_W-1:0];
                  mem_req   <= 1'b1;
                  state_reg <= REQ;
               end else if (last_spr) begin
                  state_reg <= DONE;
               end else begin
                  idx_reg <= idx_reg + 1'b1;
               end
            end

            REQ: begin
               if (mem_gnt) begin
                  mem_req   <= 1'b0;
                  state_reg <= WAIT;
               end
            end

            WAIT: begin
               // Read data is valid this cycle; publish it to the slot and move on
               slot_wr             <= 1'b1;
               slot_idx            <= idx_reg;
               slot_bits           <= mem_rdata;
               slot_x              <= spr_x_arr[idx_reg];
               slot_valid[idx_reg] <= 1'b1;
               if (last_spr) begin
                  state_reg <= DONE;
               end else begin
                  idx_reg   <= idx_reg + 1'b1;
                  state_reg <= CHECK;
               end
            end

            DONE: begin
               done      <= 1'b1;
               busy      <= 1'b0;
               state_reg <= IDLE;
            end

            default: begin
               state_reg <= IDLE;
               busy      <= 1'b0;
               mem_req   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sprite_line_scheduler.sv
// Self-checking bench for sprite_line_scheduler: a memory responder with
// programmable grant stall, a scoreboard of expected fetch addresses and slot
// loads, and directed plus randomised line schedules.
module tb_sprite_line_scheduler;

   logic        clk;
   logic        rst;
   logic        line_start;
   logic [7:0]  next_line;
   logic [3:0]  spr_en;
   logic [31:0] spr_x;
   logic [31:0] spr_y;
   logic        mem_req;
   logic [5:0]  mem_addr;
   logic        mem_gnt;
   logic [11:0] mem_rdata;
   logic        slot_wr;
   logic [1:0]  slot_idx;
   logic [11:0] slot_bits;
   logic [7:0]  slot_x;
   logic [3:0]  slot_valid;
   logic        busy;
   logic        done;
   logic        overrun;
   logic        overrun_clr;

   sprite_line_scheduler dut (
      .clk         (clk),
      .rst         (rst),
      .line_start  (line_start),
      .next_line   (next_line),
      .spr_en      (spr_en),
      .spr_x       (spr_x),
      .spr_y       (spr_y),
      .mem_req     (mem_req),
      .mem_addr    (mem_addr),
      .mem_gnt     (mem_gnt),
      .mem_rdata   (mem_rdata),
      .slot_wr     (slot_wr),
      .slot_idx    (slot_idx),
      .slot_bits   (slot_bits),
      .slot_x      (slot_x),
      .slot_valid  (slot_valid),
      .busy        (busy),
      .done        (done),
      .overrun     (overrun),
      .overrun_clr (overrun_clr)
   );

   typedef struct {
      logic [1:0]  idx;
      logic [11:0] bits;
      logic [7:0]  x;
   } slot_t;

   slot_t       exp_slot_q [$];
   logic [5:0]  exp_addr_q [$];
   logic [3:0]  exp_valid;
   logic [11:0] mem_data [64];
   logic [5:0]  cur_exp_addr;
   logic [5:0]  gnt_addr;
   logic        req_prev;
   logic        auto_mem;
   int          stall_left;
   int          done_cnt;
   int          wr_cnt;
   int          n_checks;
   int          n_pass;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   // Reference model: which sprites cover this line, what they fetch and what lands in the slots
   function automatic int model_push(input logic [7:0] line);
      int hits;
      hits      = 0;
      exp_valid = '0;
      for (int i = 0; i < 4; i++) begin
         int         dl;
         logic [5:0] a;
         slot_t      s;
         dl = int'(line) - int'(spr_y[8*i +: 8]);
         if (spr_en[i] && dl >= 0 && dl < 12) begin
            a      = {2'(i), 4'(dl)};
            s.idx  = 2'(i);
            s.bits = mem_data[a];
            s.x    = spr_x[8*i +: 8];
            exp_addr_q.push_back(a);
            exp_slot_q.push_back(s);
            exp_valid[i] = 1'b1;
            hits++;
         end
      end
      return hits;
   endfunction

   task automatic set_spr(input int i, input logic en, input logic [7:0] x, input logic [7:0] y);
      spr_en[i]        = en;
      spr_x[8*i +: 8]  = x;
      spr_y[8*i +: 8]  = y;
   endtask

   // Memory responder: grants after stall_left withheld cycles, returns data the cycle after grant
   initial begin
      mem_gnt   = 1'b0;
      mem_rdata = '0;
      gnt_addr  = '0;
      forever begin
         @(posedge clk);
         #1;
         if (auto_mem) begin
            if (mem_gnt) begin
               mem_gnt   = 1'b0;
               mem_rdata = mem_data[gnt_addr];
            end else if (mem_req) begin
               if (stall_left > 0) begin
                  stall_left--;
               end else begin
                  mem_gnt  = 1'b1;
                  gnt_addr = mem_addr;
               end
            end
         end
      end
   end

   // Output monitor: scoreboard for fetch addresses and slot loads
   initial begin
      req_prev = 1'b0;
      forever begin
         @(negedge clk);
         if (done === 1'b1) done_cnt++;
         if (slot_wr === 1'b1) begin
            wr_cnt++;
            if (exp_slot_q.size() == 0) begin
               check_val("slot_wr_unexpected", 32'(slot_wr), 32'd0);
            end else begin
               slot_t e;
               e = exp_slot_q.pop_front();
               check_val("slot_idx", 32'(slot_idx), 32'(e.idx));
               check_val("slot_bits", 32'(slot_bits), 32'(e.bits));
               check_val("slot_x", 32'(slot_x), 32'(e.x));
               $display("slot load idx=%0d bits=0x%03h x=%0d", slot_idx, slot_bits, slot_x);
            end
         end
         if (mem_req === 1'b1) begin
            if (!req_prev) begin
               if (exp_addr_q.size() == 0) begin
                  check_val("mem_req_unexpected", 32'(mem_req), 32'd0);
                  cur_exp_addr = mem_addr;
               end else begin
                  cur_exp_addr = exp_addr_q.pop_front();
               end
            end
            check_val("mem_addr", 32'(mem_addr), 32'(cur_exp_addr));
         end
         req_prev = (mem_req === 1'b1);
      end
   end

   // Schedule one line and check latency, completion and final slot state
   task automatic run_line(input logic [7:0] line, input int exp_lat, input string tag);
      int n;
      int d0;
      int hits;
      int lat;
      hits = model_push(line);
      lat  = (exp_lat < 0) ? (6 + 2 * hits) : exp_lat;
      d0   = done_cnt;
      next_line  = line;
      line_start = 1'b1;
      @(posedge clk);
      #1;
      line_start = 1'b0;
      n = 1;
      check_val({tag, "_busy"}, 32'(busy), 32'd1);
      while (done !== 1'b1 && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      check_val({tag, "_latency"}, 32'(n), 32'(lat));
      @(posedge clk);
      #1;
      check_val({tag, "_done_pulses"}, 32'(done_cnt - d0), 32'd1);
      check_val({tag, "_busy_end"}, 32'(busy), 32'd0);
      check_val({tag, "_slot_valid"}, 32'(slot_valid), 32'(exp_valid));
      check_val({tag, "_pending_slots"}, 32'(exp_slot_q.size()), 32'd0);
      $display("line %0d [%s] done after %0d cycles, slot_valid=%b", line, tag, n, slot_valid);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int n;
      n_checks    = 0;
      n_pass      = 0;
      done_cnt    = 0;
      wr_cnt      = 0;
      auto_mem    = 1'b1;
      stall_left  = 0;
      rst         = 1'b1;
      line_start  = 1'b0;
      next_line   = '0;
      spr_en      = '0;
      spr_x       = '0;
      spr_y       = '0;
      overrun_clr = 1'b0;
      cur_exp_addr = '0;
      for (int i = 0; i < 64; i++) mem_data[i] = 12'($urandom);

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check_val("rst_mem_req", 32'(mem_req), 32'd0);
      check_val("rst_mem_addr", 32'(mem_addr), 32'd0);
      check_val("rst_slot_wr", 32'(slot_wr), 32'd0);
      check_val("rst_slot_idx", 32'(slot_idx), 32'd0);
      check_val("rst_slot_bits", 32'(slot_bits), 32'd0);
      check_val("rst_slot_x", 32'(slot_x), 32'd0);
      check_val("rst_slot_valid", 32'(slot_valid), 32'd0);
      check_val("rst_busy", 32'(busy), 32'd0);
      check_val("rst_done", 32'(done), 32'd0);
      check_val("rst_overrun", 32'(overrun), 32'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Single hit: sprite 0 at y=10, line 15 -> row 5, address 0x05
      mem_data[6'h05] = 12'hABC;
      set_spr(0, 1'b1, 8'd40, 8'd10);
      set_spr(1, 1'b0, 8'd0, 8'd10);
      set_spr(2, 1'b0, 8'd0, 8'd10);
      set_spr(3, 1'b0, 8'd0, 8'd10);
      run_line(8'd15, 8, "single_hit");
      check_val("single_hit_valid", 32'(slot_valid), 32'b0001);

      // No hits: sprites at y=100, lines just above and just below
      for (int i = 0; i < 4; i++) set_spr(i, 1'b1, 8'(i * 20), 8'd100);
      run_line(8'd99, 6, "nohit_99");
      check_val("nohit_99_valid", 32'(slot_valid), 32'd0);
      run_line(8'd112, 6, "nohit_112");

      // Grant stall on the first of two hits (sprites 1 and 3); disabled sprites also cover the line
      set_spr(0, 1'b0, 8'd5, 8'd50);
      set_spr(1, 1'b1, 8'd77, 8'd50);
      set_spr(2, 1'b0, 8'd9, 8'd48);
      set_spr(3, 1'b1, 8'd200, 8'd45);
      stall_left = 5;
      run_line(8'd52, 15, "stall");
      check_val("stall_valid", 32'(slot_valid), 32'b1010);

      // Boundaries: no vertical wrap near 255, last covered row and first uncovered row
      for (int i = 0; i < 4; i++) set_spr(i, 1'b0, 8'd0, 8'd0);
      set_spr(0, 1'b1, 8'd3, 8'd250);
      run_line(8'd255, 8, "y250_l255");
      run_line(8'd4, 6, "y250_l4");
      set_spr(0, 1'b0, 8'd3, 8'd250);
      set_spr(2, 1'b1, 8'd66, 8'd30);
      run_line(8'd41, 8, "y30_l41");
      check_val("y30_l41_valid", 32'(slot_valid), 32'b0100);
      run_line(8'd42, 6, "y30_l42");

      // Worst case: every sprite hits with immediate grants
      for (int i = 0; i < 4; i++) set_spr(i, 1'b1, 8'(10 + i), 8'd0);
      run_line(8'd5, 14, "all_hit");

      // Randomised sprite sets
      for (int t = 0; t < 10; t++) begin
         int base;
         base = $urandom_range(0, 240);
         for (int i = 0; i < 4; i++)
            set_spr(i, 1'($urandom), 8'($urandom), 8'(base + $urandom_range(0, 15)));
         run_line(8'(base + $urandom_range(0, 15)), -1, "random");
      end

      // Overrun: line_start while busy is ignored, then set beats a simultaneous clear
      begin
         int d0;
         for (int i = 0; i < 4; i++) set_spr(i, 1'b0, 8'd0, 8'd200);
         set_spr(0, 1'b1, 8'd40, 8'd10);
         void'(model_push(8'd15));
         d0 = done_cnt;
         next_line  = 8'd15;
         line_start = 1'b1;
         @(posedge clk);
         #1;
         next_line = 8'd205;
         @(posedge clk);
         #1;
         line_start = 1'b0;
         check_val("overrun_set", 32'(overrun), 32'd1);
         line_start  = 1'b1;
         overrun_clr = 1'b1;
         @(posedge clk);
         #1;
         line_start  = 1'b0;
         overrun_clr = 1'b0;
         check_val("overrun_set_wins", 32'(overrun), 32'd1);
         n = 3;
         while (done !== 1'b1 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
         end
         check_val("overrun_latency", 32'(n), 32'd8);
         repeat (3) @(posedge clk);
         #1;
         check_val("overrun_done_pulses", 32'(done_cnt - d0), 32'd1);
         check_val("overrun_valid", 32'(slot_valid), 32'b0001);
         check_val("overrun_pending", 32'(exp_slot_q.size()), 32'd0);
         overrun_clr = 1'b1;
         @(posedge clk);
         #1;
         overrun_clr = 1'b0;
         check_val("overrun_cleared", 32'(overrun), 32'd0);
         $display("overrun sequence done after %0d cycles", n);
      end

      // Reset while the second fetch is requested; a late grant must not load a slot
      begin
         int w0;
         auto_mem = 1'b0;
         mem_gnt  = 1'b0;
         set_spr(0, 1'b1, 8'd11, 8'd10);
         set_spr(1, 1'b1, 8'd22, 8'd10);
         exp_addr_q.push_back(6'h05);
         exp_addr_q.push_back(6'h15);
         exp_slot_q.push_back('{idx: 2'd0, bits: mem_data[6'h05], x: 8'd11});
         next_line  = 8'd15;
         line_start = 1'b1;
         @(posedge clk);
         #1;
         line_start = 1'b0;
         n = 0;
         while (mem_req !== 1'b1 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
         end
         check_val("rstreq_first_req", 32'(mem_req), 32'd1);
         mem_gnt = 1'b1;
         @(posedge clk);
         #1;
         mem_gnt   = 1'b0;
         mem_rdata = mem_data[6'h05];
         n = 0;
         while (mem_req !== 1'b1 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
         end
         check_val("rstreq_second_req", 32'(mem_req), 32'd1);
         check_val("rstreq_valid_before", 32'(slot_valid), 32'b0001);
         rst = 1'b1;
         @(posedge clk);
         #1;
         rst = 1'b0;
         check_val("rstreq_mem_req", 32'(mem_req), 32'd0);
         check_val("rstreq_busy", 32'(busy), 32'd0);
         check_val("rstreq_slot_valid", 32'(slot_valid), 32'd0);
         exp_addr_q.delete();
         exp_slot_q.delete();
         w0 = wr_cnt;
         mem_gnt   = 1'b1;
         mem_rdata = 12'h5A5;
         @(posedge clk);
         #1;
         mem_gnt = 1'b0;
         repeat (4) @(posedge clk);
         #1;
         check_val("rstreq_no_slot_wr", 32'(wr_cnt - w0), 32'd0);
         check_val("rstreq_busy_after", 32'(busy), 32'd0);
         check_val("rstreq_done_after", 32'(done), 32'd0);
         $display("reset during request handled");
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/sprite_line_scheduler.md
Name: sprite_line_scheduler

Overview:
- Per-scanline sprite fetch sequencer for the sprite engine.
- On each line-start strobe (issued at the start of horizontal blanking for the next line), it tests every sprite for a vertical hit.
- For each hit it fetches that sprite's bitmap row from the shared bitmap memory through a request/grant port, and loads it into per-sprite line slots consumed by the pixel compositor.
- The CPU write path shares the memory via an external arbiter, so the scheduler must tolerate grant stalls.

Parameters:
- NUM_SPR, 4, number of sprites scanned per line (index width 2).
- SPR_W, 12, bitmap row width in pixels.
- SPR_H, 12, sprite height in rows (row index width 4).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- line_start  in  1  one-cycle strobe: begin scheduling line next_line.
- next_line  in  8  logical line number (ly) to be built; sampled with line_start.
- spr_en  in  NUM_SPR  per-sprite enable.
- spr_x  in  NUM_SPR*8  sprite X coordinates, sprite i at [8i+7:8i].
- spr_y  in  NUM_SPR*8  sprite Y coordinates, same packing.
- mem_req  out  1  bitmap row read request.
- mem_addr  out  6  {sprite index[1:0], row[3:0]}.
- mem_gnt  in  1  arbiter grant; read data returns the cycle after grant.
- mem_rdata  in  SPR_W  bitmap row data, valid the cycle after mem_gnt.
- slot_wr  out  1  one-cycle slot load strobe.
- slot_idx  out  2  slot being loaded.
- slot_bits  out  SPR_W  row bits for the slot.
- slot_x  out  8  X coordinate for the slot.
- slot_valid  out  NUM_SPR  slot i holds a row for the current line.
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle pulse when a line's schedule completes.
- overrun  out  1  sticky: line_start arrived while not IDLE.
- overrun_clr  in  1  clears overrun.

Behaviour:
- Reset values: all outputs 0; state IDLE; idx = 0; line_q = 0.
- States: IDLE, CHECK, REQ, WAIT, DONE.
- IDLE:
  - On line_start, latch line_q = next_line, set idx = 0, clear slot_valid to 0, go to CHECK.
  - busy rises the next cycle.
- CHECK (one cycle per sprite):
  - diff = line_q - spr_y[idx], 8-bit.
  - hit = spr_en[idx] && (line_q >= spr_y[idx]) && (diff < SPR_H).
  - No vertical wrap: a sprite at y=250 covers lines 250..255 only.
  - If hit: latch row = diff[3:0], go to REQ.
  - Else if idx == NUM_SPR-1: go to DONE.
  - Else: idx++, stay in CHECK.
- REQ:
  - mem_req = 1 with mem_addr = {idx, row}; both held stable until mem_gnt.
  - On the mem_gnt cycle go to WAIT; mem_req deasserts in WAIT.
- WAIT:
  - Sample mem_rdata.
  - On the next cycle: slot_wr = 1, slot_idx = idx, slot_bits = mem_rdata, slot_x = spr_x[idx], and slot_valid[idx] set.
  - Then advance exactly as in CHECK's no-hit path (next sprite, or DONE after the last).
- DONE: done = 1 for one cycle, then IDLE.
- Latency from line_start:
  - No hits: 1 + NUM_SPR + 1 cycles to done (6 for NUM_SPR=4).
  - Each hit adds 2 cycles plus grant wait cycles.
  - Worst case with immediate grants: 14 cycles.
- line_start when not IDLE (including the DONE cycle):
  - Ignored; the schedule in progress continues.
  - overrun is set the next cycle.
- overrun_clr and an overrun event in the same cycle: set wins.
- Sprite inputs are sampled live in CHECK/WAIT; the CPU must not change them during busy.
- Priority between slots is not resolved here; the compositor handles it.
- rst mid-operation: the next cycle is IDLE with mem_req = 0, slot_valid = 0, and no slot_wr or done.
  - A pending grant or rdata after reset is ignored.

Test Plan:
- Single hit: spr_en = 0001, spr_y0 = 10, spr_x0 = 40, line_start with next_line = 15, gnt immediate, rdata = 0xABC.
  - mem_addr = 0x05.
  - slot_wr with idx 0, bits 0xABC, x 40.
  - slot_valid = 0001.
  - done at cycle 8.
- No hits: all sprites enabled with spr_y = 100, next_line = 99 and then next_line = 112.
  - No mem_req.
  - done 6 cycles after line_start.
  - slot_valid = 0.
- Grant stall: two hits (sprites 1 and 3), gnt withheld 5 cycles on the first request.
  - mem_req and mem_addr stay stable throughout the stall.
  - slot loads occur in order 1 then 3.
  - slot_valid = 1010.
- Boundary: spr_y = 250, next_line = 255 gives a hit with row 5; next_line = 4 gives no hit.
  - Also line_q = spr_y + 11 hits, spr_y + 12 misses.
- Overrun: line_start while busy.
  - overrun = 1, the current schedule is unaffected, a single done pulse.
  - overrun_clr in the same cycle as a second overrun event leaves overrun = 1.
- Reset in REQ: assert rst while mem_req = 1.
  - Next cycle: mem_req = 0, busy = 0, slot_valid = 0.
  - A following mem_gnt produces no slot_wr.
